// File: rtl/ramp_tick_pwm.sv
// Period tick down-counter plus a WIDTH-bit PWM modulator for the ramp generator.
// Define PWM_DUTY_LATCH_EN to latch the duty code at frame boundaries (glitch-free frames).
module ramp_tick_pwm #(
   parameter int PERIOD = 390,
   parameter int WIDTH  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] duty_cycle,
   output logic             zero,
   output logic             pwm_out
);

   localparam int              CW     = $clog2(PERIOD) + 1;
   localparam logic [CW-1:0]    RELOAD = CW'(PERIOD - 1);
   localparam logic [WIDTH-1:0] PMAX   = '1;

   if (PERIOD < 1) begin : g_bad_period
      $error("ramp_tick_pwm: PERIOD must be >= 1");
   end
   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("ramp_tick_pwm: WIDTH must be in 1..16");
   end

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pcnt_q, pcnt_d;
   logic             pwm_q, pwm_d;
   logic [WIDTH-1:0] duty_eff;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   // Gated by reset_n so the tick is low during reset even when PERIOD=1.
   assign zero    = enable & reset_n & cnt_zero;
   assign pwm_out = pwm_q;

   always_comb begin
      cnt_d = RELOAD;
      if (enable && !cnt_zero) cnt_d = cnt_q - CW'(1);
   end

   always_comb begin
      pcnt_d = '0;
      if (enable) pcnt_d = pcnt_q + WIDTH'(1);
   end

   assign pwm_d = enable & (pcnt_q < duty_eff);

`ifdef PWM_DUTY_LATCH_EN
   logic [WIDTH-1:0] duty_q, duty_d;

   // Reload while idle so the first frame after enable already uses the current code.
   always_comb begin
      duty_d = duty_q;
      if (!enable || pcnt_q == PMAX) duty_d = duty_cycle;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) duty_q <= '0;
      else          duty_q <= duty_d;
   end

   assign duty_eff = duty_q;
`else
   assign duty_eff = duty_cycle;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= RELOAD;
         pcnt_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pcnt_q <= pcnt_d;
         pwm_q  <= pwm_d;
      end
   end

endmodule

// File: tb/tb_ramp_tick_pwm.sv
// Scoreboard bench for ramp_tick_pwm: stimulus queues expected tick cycles, PWM high-run
// lengths and PERIOD=1 per-cycle values; a negedge monitor pops and compares.
module tb_ramp_tick_pwm;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       en_b = 1'b0;
   logic [7:0] duty = 8'd0;
   logic [1:0] duty_b = 2'd1;
   logic       zero, pwm_out, zero_b, pwm_b;

   int checks = 0;
   int errors = 0;

   int         exp_zero[$];
   int         exp_hi[$];
   logic [1:0] exp_b[$];
   bit         zmon = 1'b0;
   bit         bmon = 1'b0;
   int         en_cyc = 0;
   int         run = 0;
   int         runs = 0;

   always #5 clk = ~clk;

   ramp_tick_pwm #(.PERIOD(4), .WIDTH(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .duty_cycle(duty),
      .zero(zero), .pwm_out(pwm_out)
   );

   ramp_tick_pwm #(.PERIOD(1), .WIDTH(2)) u_p1 (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .duty_cycle(duty_b),
      .zero(zero_b), .pwm_out(pwm_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: en_cyc counts enabled cycles since enable rose (1 = first enabled cycle).
   always @(negedge clk) begin
      logic [1:0] e;
      if (!reset_n || !enable) en_cyc = 0;
      else                     en_cyc++;
      if (!enable) chk("zero_while_disabled", zero, 0);
      else if (zero && zmon) begin
         if (exp_zero.size() == 0) chk("zero_unexpected", en_cyc, 0);
         else                      chk("zero_tick_cycle", en_cyc, exp_zero.pop_front());
      end
      if (pwm_out) run++;
      else if (run > 0) begin
         runs++;
         if (exp_hi.size() == 0) chk("pwm_run_unexpected", run, 0);
         else                    chk("pwm_run_len", run, exp_hi.pop_front());
         run = 0;
      end
      if (bmon) begin
         if (exp_b.size() == 0) chk("p1_unexpected", {zero_b, pwm_b}, 0);
         else begin
            e = exp_b.pop_front();
            chk("p1_zero", zero_b, e[1]);
            chk("p1_pwm", pwm_b, e[0]);
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      logic en_v[12];
      logic z_v[12];
      logic p_v[12];
      en_v = '{1,1,1,1,1,1,0,1,1,1,1,1};
      z_v  = '{1,1,1,1,1,1,0,1,1,1,1,1};
      p_v  = '{0,1,0,0,0,1,0,0,1,0,0,0};

      #2;
      chk("rst_zero", zero, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_p1_pwm", pwm_b, 0);
      cycles(2);
      reset_n = 1'b1;
      cycles(2);

      // Tick spacing, PERIOD=4
      zmon = 1'b1;
      exp_zero = '{4, 8, 12};
      enable = 1'b1;
      cycles(14);
      enable = 1'b0;
      cycles(5);
      zmon = 1'b0;
      chk("zero_ticks_left", exp_zero.size(), 0);

      // Duty 64: two frames
      duty = 8'd64;
      cycles(2);
      exp_hi.push_back(64);
      exp_hi.push_back(64);
      enable = 1'b1;
      cycles(512);
      enable = 1'b0;
      cycles(3);
      chk("duty64_runs_left", exp_hi.size(), 0);

      // Duty 0: never high
      duty = 8'd0;
      r0 = runs;
      enable = 1'b1;
      cycles(300);
      enable = 1'b0;
      cycles(3);
      chk("duty0_runs", runs - r0, 0);

      // Duty 255: 255 high, 1 low per frame
      duty = 8'd255;
      cycles(2);
      exp_hi.push_back(255);
      exp_hi.push_back(255);
      enable = 1'b1;
      cycles(512);
      enable = 1'b0;
      cycles(3);
      chk("duty255_runs_left", exp_hi.size(), 0);

      // Duty 64 -> 128 while pcnt=10
      duty = 8'd64;
      cycles(2);
`ifdef PWM_DUTY_LATCH_EN
      exp_hi.push_back(64);
`else
      exp_hi.push_back(128);
`endif
      exp_hi.push_back(128);
      enable = 1'b1;
      cycles(10);
      duty = 8'd128;
      cycles(502);
      enable = 1'b0;
      cycles(3);
      chk("midframe_runs_left", exp_hi.size(), 0);

      // Asynchronous reset mid-frame, in a cycle where zero is high
      duty = 8'd64;
      cycles(2);
      zmon = 1'b1;
      exp_zero = '{4, 8, 12, 16, 20, 24};
      exp_hi.push_back(26);
      enable = 1'b1;
      cycles(27);
      chk("pre_rst_zero", zero, 1);
      chk("pre_rst_pwm", pwm_out, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_zero", zero, 0);
      chk("async_rst_pwm", pwm_out, 0);
      enable = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(2);
      exp_zero.push_back(4);
      exp_zero.push_back(8);
      exp_hi.push_back(9);
      enable = 1'b1;
      cycles(9);
      enable = 1'b0;
      cycles(3);
      zmon = 1'b0;
      chk("post_rst_ticks_left", exp_zero.size(), 0);
      chk("post_rst_runs_left", exp_hi.size(), 0);

      // PERIOD=1 instance: tick every enabled cycle, one-cycle enable drop restarts pcnt
      bmon = 1'b1;
      for (int i = 0; i < 12; i++) begin
         en_b = en_v[i];
         exp_b.push_back({z_v[i], p_v[i]});
         cycles(1);
      end
      bmon = 1'b0;
      en_b = 1'b0;
      cycles(2);
      chk("p1_left", exp_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
